// File: rtl/vedic_8x8.sv
// Registered 8x8 unsigned multiplier built from an Urdhva-Tiryagbhyam (Vedic) hierarchy.
// The combinational tree is half adder -> 2x2 -> 4x4 -> 8x8 core, and the top registers the core result.

module vedic_ha (
    input  logic x,
    input  logic y,
    output logic s,
    output logic co
);
    assign s  = x ^ y;
    assign co = x & y;
endmodule

module vedic_2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic c1;

    assign p[0] = a[0] & b[0];

    // The two cross terms give bit 1. Their carry joins a1&b1 to give bits 2 and 3.
    vedic_ha u_ha0 (.x(a[1] & b[0]), .y(a[0] & b[1]), .s(p[1]), .co(c1));
    vedic_ha u_ha1 (.x(a[1] & b[1]), .y(c1),          .s(p[2]), .co(p[3]));
endmodule

module vedic_4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0] ll, hl, lh, hh;

    vedic_2x2 u_ll (.a(a[1:0]), .b(b[1:0]), .p(ll));
    vedic_2x2 u_hl (.a(a[3:2]), .b(b[1:0]), .p(hl));
    vedic_2x2 u_lh (.a(a[1:0]), .b(b[3:2]), .p(lh));
    vedic_2x2 u_hh (.a(a[3:2]), .b(b[3:2]), .p(hh));

    // The operands are widened to the full 8 bits before the add, so the sum cannot overflow (max 225).
    assign p = {4'b0, ll} + {2'b0, hl, 2'b0} + {2'b0, lh, 2'b0} + {hh, 4'b0};
endmodule

module vedic_8x8_core (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    logic [7:0] ll, hl, lh, hh;

    vedic_4x4 u_ll (.a(a[3:0]), .b(b[3:0]), .p(ll));
    vedic_4x4 u_hl (.a(a[7:4]), .b(b[3:0]), .p(hl));
    vedic_4x4 u_lh (.a(a[3:0]), .b(b[7:4]), .p(lh));
    vedic_4x4 u_hh (.a(a[7:4]), .b(b[7:4]), .p(hh));

    assign p = {8'b0, ll} + {4'b0, hl, 4'b0} + {4'b0, lh, 4'b0} + {hh, 8'b0};
endmodule

module vedic_8x8 (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] c
);
    logic [15:0] product;

    vedic_8x8_core u_core (.a(a), .b(b), .p(product));

    // This is a one-cycle pipeline with no enable. A new pair is accepted on every edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            c <= 16'h0000;
        end else begin
            c <= product;
        end
    end
endmodule

// File: tb/tb_vedic_8x8.sv
// Bench for vedic_8x8. A queue holds the expected products while they wait out the one-cycle latency.
// After each edge the bench pops the oldest entry and compares it with c.

module tb_vedic_8x8;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] c;

    logic [15:0] exp_q[$];
    logic [15:0] exp_v;
    int          checks   = 0;
    int          failures = 0;

    vedic_8x8 dut (.clk(clk), .rst(rst), .a(a), .b(b), .c(c));

    always #5 clk = ~clk;

    // Drive one cycle of stimulus and queue the result it should produce.
    task automatic drive(input logic [7:0] av, input logic [7:0] bv, input logic rv);
        a   = av;
        b   = bv;
        rst = rv;
        exp_q.push_back(rv ? 16'h0000 : (16'(av) * 16'(bv)));
    endtask

    // Advance past the next rising edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
            step();
            exp_v = exp_q.pop_front();
            checks++;
            if (c !== exp_v) begin
                failures++;
                $display("FAIL reset[%0d]: c=%0d expected=%0d", i, c, exp_v);
            end
        end
    endtask

    task automatic test_zero_and_max();
        logic [7:0] av[3] = '{8'd0, 8'd255, 8'd1};
        logic [7:0] bv[3] = '{8'd0, 8'd255, 8'd255};
        for (int i = 0; i < 3; i++) begin
            drive(av[i], bv[i], 1'b0);
            step();
            exp_v = exp_q.pop_front();
            checks++;
            if (c !== exp_v) begin
                failures++;
                $display("FAIL corner %0d*%0d: c=%0d expected=%0d", av[i], bv[i], c, exp_v);
            end
        end
    endtask

    task automatic test_held();
        logic [7:0] av[4] = '{8'd5, 8'd4, 8'd2, 8'd6};
        logic [7:0] bv[4] = '{8'd3, 8'd2, 8'd2, 8'd8};
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 3; k++) begin
                drive(av[i], bv[i], 1'b0);
                step();
                exp_v = exp_q.pop_front();
                checks++;
                if (c !== exp_v) begin
                    failures++;
                    $display("FAIL held %0d*%0d edge%0d: c=%0d expected=%0d", av[i], bv[i], k, c, exp_v);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  av[3] = '{8'd255, 8'd5, 8'd6};
        logic [7:0]  bv[3] = '{8'd255, 8'd3, 8'd8};
        logic [15:0] lit[3] = '{16'd65025, 16'd15, 16'd48};
        for (int i = 0; i < 3; i++) begin
            drive(av[i], bv[i], 1'b0);
            step();
            exp_v = exp_q.pop_front();
            checks++;
            if (c !== exp_v || c !== lit[i]) begin
                failures++;
                $display("FAIL back_to_back[%0d]: c=%0d expected=%0d", i, c, lit[i]);
            end
        end
    endtask

    task automatic test_midstream_reset();
        logic rv[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(8'd200, 8'd100, rv[i]);
            step();
            exp_v = exp_q.pop_front();
            checks++;
            if (c !== exp_v) begin
                failures++;
                $display("FAIL midstream_reset[%0d] rst=%0b: c=%0d expected=%0d", i, rv[i], c, exp_v);
            end
        end
    endtask

    task automatic test_sync_only_reset();
        drive(8'd9, 8'd7, 1'b0);
        step();
        exp_v = exp_q.pop_front();
        checks++;
        if (c !== exp_v) begin
            failures++;
            $display("FAIL sync_load: c=%0d expected=%0d", c, exp_v);
        end
        // Raise rst between edges. c must not move until the next edge.
        drive(8'd9, 8'd7, 1'b1);
        #2;
        checks++;
        if (c !== 16'd63) begin
            failures++;
            $display("FAIL sync_no_async_clear: c=%0d expected=63", c);
        end
        step();
        exp_v = exp_q.pop_front();
        checks++;
        if (c !== exp_v) begin
            failures++;
            $display("FAIL sync_clear_at_edge: c=%0d expected=%0d", c, exp_v);
        end
    endtask

    task automatic test_random();
        logic [7:0] av, bv;
        for (int i = 0; i < 3000; i++) begin
            av = 8'($urandom_range(0, 255));
            bv = 8'($urandom_range(0, 255));
            drive(av, bv, 1'b0);
            step();
            exp_v = exp_q.pop_front();
            checks++;
            if (c !== exp_v) begin
                failures++;
                $display("FAIL random %0d*%0d: c=%0d expected=%0d", av, bv, c, exp_v);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a   = 8'd0;
        b   = 8'd0;
        #1;
        test_reset();
        test_zero_and_max();
        test_held();
        test_back_to_back();
        test_midstream_reset();
        test_sync_only_reset();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: left=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
